// File: rtl/codec_config_sequencer.sv
// Writes a fixed table of codec registers through the I2C master, one 24-bit word per transaction.
// Optional retry support on NACK/timeout is built when CODEC_CFG_RETRY_EN is defined.
module codec_config_sequencer #(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         GAP_CYCLES     = 1000,
  parameter int         TIMEOUT_CYCLES = 1048576,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic        inClock,
  input  logic        reset,
  input  logic        start,
  output logic        i2cReset,
  output logic [23:0] i2cData,
  input  logic        i2cReady,
  input  logic        i2cAck,
  output logic        busy,
  output logic        configured,
  output logic        error,
  output logic [3:0]  entryIndex,
  output logic [2:0]  debugState
);

  localparam int         GAP_W       = $clog2(GAP_CYCLES + 1);
  localparam int         TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] NUM_ENTRIES = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_CHECK, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_next;
  logic              load_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [3:0]        index;
  logic              pass;
  logic              ready_s1, ready_s2, ready_s3, ack_s1, ack_s2;
  logic              start_ok, ready_rise, ready_fall, tmo_hit, gap_end, give_up;

  function automatic logic [23:0] make_word(input logic [3:0] idx);
    logic [15:0] e;  // {reg[6:0], val[8:0]}
    case (idx)
      4'd0:    e = {7'h0F, 9'h000};
      4'd1:    e = {7'h06, 9'h000};
      4'd2:    e = {7'h00, 9'h017};
      4'd3:    e = {7'h01, 9'h017};
      4'd4:    e = {7'h02, 9'h079};
      4'd5:    e = {7'h03, 9'h079};
      4'd6:    e = {7'h04, 9'h012};
      4'd7:    e = {7'h05, 9'h000};
      4'd8:    e = {7'h07, 9'h042};
      4'd9:    e = {7'h08, 9'h000};
      4'd10:   e = {7'h09, 9'h001};
      default: e = 16'h0000;
    endcase
    return {DEV_ADDR, e};
  endfunction

  // Master handshake: i2cReady rises when a transfer begins and falls when it ends,
  // with i2cAck valid at the fall; both are asynchronous and go through 2-flop syncs.
  assign ready_rise = ready_s2 & ~ready_s3;
  assign ready_fall = ~ready_s2 & ready_s3;
  assign start_ok   = start & (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign gap_end    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

`ifdef CODEC_CFG_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRIES + 2);
  logic [RTY_W-1:0] retry_cnt;

  always_ff @(posedge inClock or negedge reset) begin
    if (!reset)                 retry_cnt <= '0;
    else if (start_ok)          retry_cnt <= '0;
    else if (state == S_CHECK)  retry_cnt <= pass ? '0 : retry_cnt + RTY_W'(1);
  end

  assign give_up = (retry_cnt > RTY_W'(MAX_RETRIES));
`else
  // No retry counter in this build: any failed word ends the sequence.
  localparam bit RETRY_CFG_OK = (MAX_RETRIES >= 0);
  assign give_up = ~pass & RETRY_CFG_OK;
`endif

  always_ff @(posedge inClock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      load_cnt <= 1'b0;
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
      index    <= 4'd0;
      pass     <= 1'b0;
      i2cData  <= 24'd0;
      ready_s1 <= 1'b0;
      ready_s2 <= 1'b0;
      ready_s3 <= 1'b0;
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
    end else begin
      state    <= state_next;
      ready_s1 <= i2cReady;
      ready_s2 <= ready_s1;
      ready_s3 <= ready_s2;
      ack_s1   <= i2cAck;
      ack_s2   <= ack_s1;
      load_cnt <= (state == S_LOAD) ? ~load_cnt : 1'b0;
      tmo_cnt  <= (state == S_WAIT_BUSY || state == S_WAIT_DONE) ? tmo_cnt + TMO_W'(1) : '0;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      // Word is latched on entry to LOAD so it is valid for the whole LOAD window.
      if (state_next == S_LOAD && state != S_LOAD)
        i2cData <= make_word(start_ok ? 4'd0 : index);
      if (start_ok)
        index <= 4'd0;
      else if (state == S_CHECK && pass)
        index <= index + 4'd1;
      if (state == S_WAIT_DONE && ready_fall)
        pass <= ack_s2;
      else if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && tmo_hit)
        pass <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start_ok) state_next = S_LOAD;
      S_LOAD:      if (load_cnt) state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (ready_rise) state_next = S_WAIT_DONE;
                   else if (tmo_hit) state_next = S_CHECK;
      S_WAIT_DONE: if (ready_fall || tmo_hit) state_next = S_CHECK;
      S_CHECK:     state_next = S_GAP;
      S_GAP: begin
        if (gap_end) begin
          if (give_up)                    state_next = S_ERROR;
          else if (index == NUM_ENTRIES)  state_next = S_DONE;
          else                            state_next = S_LOAD;
        end
      end
      S_DONE, S_ERROR: if (start_ok) state_next = S_LOAD;
      default:     state_next = S_IDLE;
    endcase
  end

  assign i2cReset   = !(state == S_WAIT_BUSY || state == S_WAIT_DONE);
  assign busy       = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign configured = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign entryIndex = index;
  assign debugState = state;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: behavioural I2C master, table of scenarios, random NACK plans.
module tb_codec_config_sequencer;
  localparam int GAP  = 4;
  localparam int TMO  = 64;
  localparam int MAXR = 3;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        i2c_ready = 1'b0, i2c_ack = 1'b0;
  logic        i2c_reset, busy, configured, error;
  logic [23:0] i2c_data;
  logic [3:0]  entry_index;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  codec_config_sequencer #(
    .DEV_ADDR(8'h34), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
  ) dut (
    .inClock(clk), .reset(rst_n), .start(start), .i2cReset(i2c_reset), .i2cData(i2c_data),
    .i2cReady(i2c_ready), .i2cAck(i2c_ack), .busy(busy), .configured(configured),
    .error(error), .entryIndex(entry_index), .debugState(dbg_state)
  );

  int          errors = 0, checks = 0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [7:0]  rom_reg[11] = '{8'h0F, 8'h06, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h09};
  logic [8:0]  rom_val[11] = '{9'h000, 9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h042, 9'h000, 9'h001};

  // Master model controls
  logic [23:0] nack_word = 24'hFFFFFF;
  int          nack_left = 0;
  bit          nack_forever = 0, never_ready = 0, hold_long = 0, first_txn = 1, in_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] word_of(input int e);
    logic [7:0] r;
    r = rom_reg[e];
    return {8'h34, r[6:0], rom_val[e]};
  endfunction

  // Reference: each entry is retried until it passes or its failures exceed the allowance.
  task automatic build_exp(input int nidx, input int ncnt, input bit forever_fail,
                           output bit e_cfg, output bit e_err, output int e_idx);
    int allowed, fails;
`ifdef CODEC_CFG_RETRY_EN
    allowed = MAXR;
`else
    allowed = 0;
`endif
    exp_q.delete();
    e_cfg = 1; e_err = 0; e_idx = 11;
    for (int e = 0; e < 11; e++) begin
      fails = (e == nidx) ? (forever_fail ? allowed + 1 : ncnt) : 0;
      if (fails > allowed) begin
        repeat (allowed + 1) exp_q.push_back(word_of(e));
        e_cfg = 0; e_err = 1; e_idx = e;
        return;
      end
      repeat (fails + 1) exp_q.push_back(word_of(e));
    end
  endtask

  // Behavioural I2C master
  initial begin
    int hi_cnt, n, d1, d2;
    logic [23:0] w;
    bit ok, aborted;
    hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (i2c_reset !== 1'b0) begin hi_cnt++; continue; end
      w = i2c_data;
      obs_q.push_back(w);
      if (!first_txn) check("gap_len", 32'(hi_cnt), 32'(GAP + 3));
      first_txn = 0;
      if (never_ready) begin
        n = 0;
        while (i2c_reset === 1'b0 && n < 4 * TMO) begin n++; @(negedge clk); end
        check("timeout_len", 32'(n), 32'(TMO));
      end else begin
        ok = !((w == nack_word) && (nack_forever || nack_left > 0));
        if (!ok && !nack_forever) nack_left--;
        aborted = 0;
        d1 = $urandom_range(0, 3);
        for (int k = 0; k < d1 && !aborted; k++) begin @(negedge clk); if (i2c_reset) aborted = 1; end
        if (!aborted) begin
          i2c_ready = 1; in_ready = 1;
          d2 = hold_long ? 12 : $urandom_range(1, 4);
          for (int k = 0; k < d2 && !aborted; k++) begin @(negedge clk); if (i2c_reset) aborted = 1; end
          in_ready = 0;
          i2c_ready = 0;
          if (!aborted) begin
            i2c_ack = ok;
            n = 0;
            while (i2c_reset === 1'b0 && n < 100) begin @(negedge clk); n++; end
            // 2 sync cycles to CHECK, then i2cReset is high from the CHECK cycle
            check("done_latency", 32'(n), 32'd3);
            i2c_ack = 0;
          end
        end
      end
      hi_cnt = 1;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    obs_q.delete();
    first_txn = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_cfg_clr", 32'(configured), 32'd0);
    check("start_err_clr", 32'(error), 32'd0);
    check("load1_i2creset", 32'(i2c_reset), 32'd1);
    @(negedge clk);
    check("load2_i2creset", 32'(i2c_reset), 32'd1);
    check("load_word0", 32'(i2c_data), 32'h341E00);
    @(negedge clk);
    check("wait_i2creset", 32'(i2c_reset), 32'd0);
  endtask

  task automatic run_seq(input int nidx, input int ncnt, input bit nforever, input bit nready,
                         input bit spam, output bit e_cfg, output bit e_err, output int e_idx);
    bit done;
    build_exp(nready ? 0 : nidx, ncnt, nforever || nready, e_cfg, e_err, e_idx);
    nack_word    = (nidx >= 0 && nidx < 11) ? word_of(nidx) : 24'hFFFFFF;
    nack_left    = ncnt;
    nack_forever = nforever;
    never_ready  = nready;
    pulse_start();
    done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else start = spam && ($urandom_range(0, 19) == 0);
    end
    start = 0;
    check("seq_finished", 32'(done), 32'd1);
    check("word_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("word", 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  typedef struct {
    int nack_idx; int nack_cnt; bit nack_forever; bit never_ready; bit spam;
    bit exp_cfg; bit exp_err; int exp_idx;
  } vec_t;
  vec_t vecs[5];

  initial begin
    bit   m_cfg, m_err, found;
    int   m_idx, nidx, ncnt;
    bit   nfor;
    vecs[0] = '{-1, 0, 0, 0, 0, 1, 0, 11};
`ifdef CODEC_CFG_RETRY_EN
    vecs[1] = '{4, 1, 0, 0, 0, 1, 0, 11};
`else
    vecs[1] = '{4, 1, 0, 0, 0, 0, 1, 4};
`endif
    vecs[2] = '{2, 0, 1, 0, 0, 0, 1, 2};
    vecs[3] = '{-1, 0, 0, 1, 0, 0, 1, 0};
    vecs[4] = '{-1, 0, 0, 0, 1, 1, 0, 11};

    repeat (3) @(negedge clk);
    check("rst_i2creset", 32'(i2c_reset), 32'd1);
    check("rst_data", 32'(i2c_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg", 32'(configured), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_idx", 32'(entry_index), 32'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    foreach (vecs[v]) begin
      run_seq(vecs[v].nack_idx, vecs[v].nack_cnt, vecs[v].nack_forever, vecs[v].never_ready,
              vecs[v].spam, m_cfg, m_err, m_idx);
      check("tbl_cfg", 32'(configured), 32'(vecs[v].exp_cfg));
      check("tbl_err", 32'(error), 32'(vecs[v].exp_err));
      check("tbl_idx", 32'(entry_index), 32'(vecs[v].exp_idx));
      check("tbl_busy", 32'(busy), 32'd0);
    end

    // Async reset while entry 5 is in WAIT_DONE
    nack_word = 24'hFFFFFF; nack_left = 0; nack_forever = 0; never_ready = 0; hold_long = 1;
    pulse_start();
    found = 0;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(negedge clk);
      if (obs_q.size() == 6 && in_ready) found = 1;
    end
    check("reset_point_reached", 32'(found), 32'd1);
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1 check("async_i2creset", 32'(i2c_reset), 32'd1);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_idx", 32'(entry_index), 32'd0);
    check("mid_rst_data", 32'(i2c_data), 32'd0);
    check("mid_rst_cfg", 32'(configured), 32'd0);
    rst_n = 1;
    hold_long = 0;
    repeat (3) @(negedge clk);
    run_seq(-1, 0, 0, 0, 0, m_cfg, m_err, m_idx);
    check("after_rst_cfg", 32'(configured), 32'd1);
    check("after_rst_idx", 32'(entry_index), 32'd11);

    // Random NACK plans against the reference model
    for (int r = 0; r < 8; r++) begin
      nidx = $urandom_range(0, 10);
      ncnt = $urandom_range(0, 5);
      nfor = ($urandom_range(0, 4) == 0);
      run_seq(nidx, ncnt, nfor, 0, $urandom_range(0, 1) == 1, m_cfg, m_err, m_idx);
      check("rnd_cfg", 32'(configured), 32'(m_cfg));
      check("rnd_err", 32'(error), 32'(m_err));
      check("rnd_idx", 32'(entry_index), 32'(m_idx));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
